// File: rtl/tx_loader_pkg.sv
// Shared types and widths for the transmit frame loader.
// TX_LOADER_HDR_EN adds the two header-write states to the state enumeration.
package tx_loader_pkg;

   localparam int unsigned ADDR_W  = 11;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned CNT_W   = 20;
   localparam int unsigned HDR_LEN = 2;

`ifdef TX_LOADER_HDR_EN
   typedef enum logic [2:0] {
      ST_IDLE, ST_HDR0, ST_HDR1, ST_LOAD, ST_START, ST_GAP, ST_DROP
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_START, ST_GAP, ST_DROP
   } state_t;
`endif

   // One transmit-buffer write beat
   typedef struct packed {
      logic              wren;
      logic [ADDR_W-1:0] waddr;
      logic [DATA_W-1:0] wdata;
   } buf_wr_t;

endpackage

// File: rtl/tx_frame_loader_if.sv
// Byte-stream input, header fields and transmit-buffer/control outputs of the loader.
// master = upstream feeder side, slave = tx_frame_loader side.
interface tx_frame_loader_if;
   import tx_loader_pkg::*;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic [DATA_W-1:0] dst_addr;
   logic [DATA_W-1:0] src_addr;
   logic              tx_buf_wren;
   logic [ADDR_W-1:0] tx_buf_waddr;
   logic [DATA_W-1:0] tx_buf_wdata;
   logic [ADDR_W-1:0] tx_data_len;
   logic              tx_start;
   logic              busy;
   logic              err_ovf;

   modport master (
      output s_valid, s_data, s_last, dst_addr, src_addr,
      input  s_ready, tx_buf_wren, tx_buf_waddr, tx_buf_wdata,
      input  tx_data_len, tx_start, busy, err_ovf
   );

   modport slave (
      input  s_valid, s_data, s_last, dst_addr, src_addr,
      output s_ready, tx_buf_wren, tx_buf_waddr, tx_buf_wdata,
      output tx_data_len, tx_start, busy, err_ovf
   );

endinterface

// File: rtl/tx_gap_timer.sv
// Post-frame guard counter: load a cycle count, count down to zero, flag zero.
module tx_gap_timer
   import tx_loader_pkg::*;
(
   input  logic             wclk,
   input  logic             rst,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero_c
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge wclk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_loader.sv
// Loads application byte frames into the link-layer transmit buffer, then starts the
// frame and holds off the next one for a length-scaled guard. Optional header: TX_LOADER_HDR_EN.
module tx_frame_loader
   import tx_loader_pkg::*;
#(
   parameter int unsigned MAX_LEN     = 2047,
   parameter int unsigned BYTE_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 64
)(
   input  logic          wclk,
   input  logic          rst,
   tx_frame_loader_if.slave bus
);

   localparam logic [ADDR_W-1:0] MAX_PTR = ADDR_W'(MAX_LEN);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] len_q, len_d;
   buf_wr_t           wr_q, wr_d;
   logic              s_ready_q, s_ready_d;
   logic [ADDR_W-1:0] tx_len_q, tx_len_d;
   logic              tx_start_q, tx_start_d;
   logic              busy_q, busy_d;
   logic              err_ovf_q, err_ovf_d;
   logic              tmr_load_c, tmr_dec_c, tmr_zero_c;
   logic [CNT_W-1:0]  gap_load_c;
   logic              hs_c;

   assign hs_c       = bus.s_valid & s_ready_q;
   assign gap_load_c = CNT_W'(len_q) * CNT_W'(BYTE_CYCLES) + CNT_W'(GAP_CYCLES);

   tx_gap_timer u_gap (
      .wclk     (wclk),
      .rst      (rst),
      .load     (tmr_load_c),
      .dec      (tmr_dec_c),
      .load_val (gap_load_c),
      .zero_c   (tmr_zero_c)
   );

   // State and output registers
   always_ff @(posedge wclk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         len_q      <= '0;
         wr_q       <= '0;
         s_ready_q  <= 1'b0;
         tx_len_q   <= '0;
         tx_start_q <= 1'b0;
         busy_q     <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         len_q      <= len_d;
         wr_q       <= wr_d;
         s_ready_q  <= s_ready_d;
         tx_len_q   <= tx_len_d;
         tx_start_q <= tx_start_d;
         busy_q     <= busy_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      len_d      = len_q;
      wr_d       = '{wren: 1'b0, waddr: wr_q.waddr, wdata: wr_q.wdata};
      tx_len_d   = tx_len_q;
      tx_start_d = 1'b0;
      err_ovf_d  = 1'b0;
      tmr_load_c = 1'b0;
      tmr_dec_c  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.s_valid) begin
               ptr_d = '0;
`ifdef TX_LOADER_HDR_EN
               state_d = ST_HDR0;
`else
               state_d = ST_LOAD;
`endif
            end
         end
`ifdef TX_LOADER_HDR_EN
         ST_HDR0: begin
            wr_d    = '{wren: 1'b1, waddr: ptr_q, wdata: bus.dst_addr};
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_HDR1;
         end
         ST_HDR1: begin
            wr_d    = '{wren: 1'b1, waddr: ptr_q, wdata: bus.src_addr};
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = ST_LOAD;
         end
`endif
         ST_LOAD: begin
            if (hs_c) begin
               if (ptr_q < MAX_PTR) begin
                  wr_d  = '{wren: 1'b1, waddr: ptr_q, wdata: bus.s_data};
                  ptr_d = ptr_q + ADDR_W'(1);
                  if (bus.s_last) begin
                     len_d   = ptr_q + ADDR_W'(1);
                     state_d = ST_START;
                  end
               end else if (bus.s_last) begin
                  err_ovf_d = 1'b1;
                  state_d   = ST_IDLE;
               end else begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (hs_c && bus.s_last) begin
               err_ovf_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_START: begin
            tx_len_d   = len_q;
            tx_start_d = 1'b1;
            tmr_load_c = 1'b1;
            state_d    = ST_GAP;
         end
         ST_GAP: begin
            if (tmr_zero_c) begin
               state_d = ST_IDLE;
            end else begin
               tmr_dec_c = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
      // Ready only once a streaming state has been entered, never on its first cycle
      s_ready_d = ((state_q == ST_LOAD) || (state_q == ST_DROP)) &&
                  ((state_d == ST_LOAD) || (state_d == ST_DROP));
   end

   assign bus.s_ready      = s_ready_q;
   assign bus.tx_buf_wren  = wr_q.wren;
   assign bus.tx_buf_waddr = wr_q.waddr;
   assign bus.tx_buf_wdata = wr_q.wdata;
   assign bus.tx_data_len  = tx_len_q;
   assign bus.tx_start     = tx_start_q;
   assign bus.busy         = busy_q;
   assign bus.err_ovf      = err_ovf_q;

endmodule

// File: tb/tb_tx_frame_loader.sv
// Directed bench for tx_frame_loader; expectations follow TX_LOADER_HDR_EN when defined.
module tb_tx_frame_loader;

   localparam int unsigned BC   = 4;
   localparam int unsigned GC   = 8;
   localparam int unsigned MAXL = 2047;
`ifdef TX_LOADER_HDR_EN
   localparam int HL = 2;
   localparam int RDY_LAT = 4;
`else
   localparam int HL = 0;
   localparam int RDY_LAT = 2;
`endif

   logic wclk = 1'b0;
   logic rst;
   always #5 wclk = ~wclk;

   tx_frame_loader_if bus();

   tx_frame_loader #(.MAX_LEN(MAXL), .BYTE_CYCLES(BC), .GAP_CYCLES(GC)) dut (
      .wclk (wclk),
      .rst  (rst),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output monitor, sampled on the falling edge
   int          cyc = 0;
   logic [10:0] wa [0:4095];
   logic [7:0]  wd [0:4095];
   int          wr_n = 0, wr_last_cyc = 0;
   logic [10:0] st_len [0:15];
   int          st_c [0:15];
   int          st_n = 0, st_cyc = 0;
   int          ovf_n = 0, ovf_cyc = 0, bfall_cyc = 0, gap_viol = 0;
   logic        busy_p = 1'b0, gap_on = 1'b0;

   always @(posedge wclk) cyc <= cyc + 1;

   always @(negedge wclk) begin
      if (bus.tx_buf_wren) begin
         if (wr_n < 4096) begin
            wa[wr_n[11:0]] <= bus.tx_buf_waddr;
            wd[wr_n[11:0]] <= bus.tx_buf_wdata;
         end
         wr_n        <= wr_n + 1;
         wr_last_cyc <= cyc;
      end
      if (bus.tx_start) begin
         if (st_n < 16) begin
            st_len[st_n[3:0]] <= bus.tx_data_len;
            st_c[st_n[3:0]]   <= cyc;
         end
         st_n   <= st_n + 1;
         st_cyc <= cyc;
      end
      if (bus.err_ovf) begin
         ovf_n   <= ovf_n + 1;
         ovf_cyc <= cyc;
      end
      if (busy_p && !bus.busy) bfall_cyc <= cyc;
      busy_p <= bus.busy;
      if (bus.busy && (bus.tx_start || gap_on) && bus.s_ready) gap_viol <= gap_viol + 1;
      gap_on <= bus.tx_start | (gap_on & bus.busy);
   end

   // Stimulus state and expected write list
   logic [7:0]  fr [0:2047];
   logic [10:0] ea [0:4095];
   logic [7:0]  ed [0:4095];
   int          exp_n = 0;
   int          hs_cyc = 0, first_hs = 0;
   bit          phase = 1'b0, aborted = 1'b0;

   task automatic send_byte(input logic [7:0] d, input logic last, input bit gappy);
      int budget = 0;
      while (!aborted) begin
         @(negedge wclk);
         bus.s_data = d;
         bus.s_last = last;
         if (gappy) begin
            bus.s_valid = phase;
            phase = ~phase;
         end else begin
            bus.s_valid = 1'b1;
         end
         if (bus.s_valid && bus.s_ready) begin
            hs_cyc = cyc;
            break;
         end
         budget++;
         if (budget > 300) begin
            chk("handshake_timeout", 32'd1, 32'd0);
            aborted = 1'b1;
         end
      end
   endtask

   task automatic send_frame(input int n, input bit gappy);
      for (int i = 0; i < n; i++) begin
         send_byte(fr[i], (i == n - 1), gappy);
         if (i == 0) first_hs = hs_cyc;
      end
   endtask

   task automatic idle_bus();
      @(negedge wclk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic exp_frame(input int n);
`ifdef TX_LOADER_HDR_EN
      ea[exp_n[11:0]] = 11'd0;  ed[exp_n[11:0]] = 8'hA5;  exp_n++;
      ea[exp_n[11:0]] = 11'd1;  ed[exp_n[11:0]] = 8'h5A;  exp_n++;
`endif
      for (int i = 0; i < n; i++) begin
         if (HL + i < int'(MAXL)) begin
            ea[exp_n[11:0]] = 11'(HL + i);
            ed[exp_n[11:0]] = fr[i];
            exp_n++;
         end
      end
   endtask

   task automatic check_writes(input string tag, input int base);
      int bad = 0;
      int got = wr_n - base;
      chk({tag, "_wr_cnt"}, got, exp_n);
      for (int i = 0; i < exp_n && i < got; i++) begin
         int k = base + i;
         if (k < 4096 && (wa[k[11:0]] !== ea[i[11:0]] || wd[k[11:0]] !== ed[i[11:0]])) bad++;
      end
      chk({tag, "_wr_bad"}, bad, 0);
   endtask

   task automatic wait_starts(input string tag, input int target);
      int b = 0;
      while (st_n < target && b < 500) begin
         @(posedge wclk);
         b++;
      end
      chk({tag, "_start_seen"}, 32'(st_n >= target), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int b = 0;
      while (busy_p && b < 500) begin
         @(posedge wclk);
         b++;
      end
      chk({tag, "_idle_seen"}, 32'(busy_p), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"},  32'(bus.s_ready),      32'd0);
      chk({tag, "_wren"},     32'(bus.tx_buf_wren),  32'd0);
      chk({tag, "_waddr"},    32'(bus.tx_buf_waddr), 32'd0);
      chk({tag, "_wdata"},    32'(bus.tx_buf_wdata), 32'd0);
      chk({tag, "_len"},      32'(bus.tx_data_len),  32'd0);
      chk({tag, "_tx_start"}, 32'(bus.tx_start),     32'd0);
      chk({tag, "_busy"},     32'(bus.busy),         32'd0);
      chk({tag, "_err_ovf"},  32'(bus.err_ovf),      32'd0);
   endtask

   // Single frame with full timing checks
   task automatic run_frame(input string tag, input int n, input bit gappy);
      int base = wr_n;
      int s0   = st_n;
      int lh, len;
      exp_n = 0;
      exp_frame(n);
      len   = HL + n;
      phase = 1'b0;
      send_frame(n, gappy);
      lh = hs_cyc;
      idle_bus();
      wait_starts(tag, s0 + 1);
      wait_idle(tag);
      @(negedge wclk);
      check_writes(tag, base);
      chk({tag, "_start_len"}, 32'(st_len[s0[3:0]]), len);
      chk({tag, "_len_out"},   32'(bus.tx_data_len), len);
      chk({tag, "_last_wr"},   wr_last_cyc - lh, 1);
      chk({tag, "_start_lat"}, st_cyc - lh, 2);
      chk({tag, "_busy_fall"}, bfall_cyc - st_cyc, len * int'(BC) + int'(GC) + 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base, s0, o0, gv0, lh, n_a;
      rst = 1'b1;
      bus.s_valid  = 1'b0;
      bus.s_data   = 8'h00;
      bus.s_last   = 1'b0;
      bus.dst_addr = 8'hA5;
      bus.src_addr = 8'h5A;
      repeat (3) @(negedge wclk);
      chk_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge wclk);

      // 4-byte frame
      fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h33; fr[3] = 8'h44;
      run_frame("f4", 4, 1'b0);

      // Back-to-back: 5-byte frame immediately followed by a 3-byte frame
      base = wr_n;  s0 = st_n;  gv0 = gap_viol;  exp_n = 0;
      n_a = 5;
      for (int i = 0; i < n_a; i++) fr[i] = 8'(8'hA1 + i);
      exp_frame(n_a);
      send_frame(n_a, 1'b0);
      for (int i = 0; i < 3; i++) fr[i] = 8'(8'hB1 + i);
      exp_frame(3);
      send_frame(3, 1'b0);
      idle_bus();
      wait_starts("b2b", s0 + 2);
      wait_idle("b2b");
      @(negedge wclk);
      check_writes("b2b", base);
      chk("b2b_starts",    st_n - s0, 2);
      chk("b2b_len_a",     32'(st_len[s0[3:0]]), HL + n_a);
      chk("b2b_len_b",     32'(st_len[4'(s0 + 1)]), HL + 3);
      chk("b2b_gap_ready", gap_viol - gv0, 0);
      chk("b2b_next_hs",   first_hs - st_c[s0[3:0]], (HL + n_a) * int'(BC) + int'(GC) + 1 + RDY_LAT);

      // Oversize frame of 2048 bytes
      base = wr_n;  s0 = st_n;  o0 = ovf_n;  exp_n = 0;
      for (int i = 0; i < 2048; i++) fr[i] = 8'(i);
      exp_frame(2048);
      send_frame(2048, 1'b0);
      lh = hs_cyc;
      idle_bus();
      repeat (6) @(negedge wclk);
      check_writes("ovf", base);
      chk("ovf_no_start", st_n - s0, 0);
      chk("ovf_len_kept", 32'(bus.tx_data_len), HL + 3);
      chk("ovf_pulses",   ovf_n - o0, 1);
      chk("ovf_timing",   ovf_cyc - lh, 1);
      chk("ovf_busy",     32'(bus.busy), 32'd0);

      // Reset after 10 bytes of a frame
      s0 = st_n;
      for (int i = 0; i < 10; i++) send_byte(8'(8'h60 + i), 1'b0, 1'b0);
      @(negedge wclk);
      bus.s_valid = 1'b0;
      rst = 1'b1;
      @(negedge wclk);
      chk_all_zero("rst_mid");
      rst = 1'b0;
      repeat (5) @(negedge wclk);
      chk("rst_no_start", st_n - s0, 0);
      fr[0] = 8'h77; fr[1] = 8'h88;
      run_frame("post_rst", 2, 1'b0);

      // s_valid toggling every other cycle
      for (int i = 0; i < 6; i++) fr[i] = 8'(8'hC0 + i);
      run_frame("gappy", 6, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tx_frame_loader.md
# tx_frame_loader

Upstream feeder for the M-bus transmit link layer. Accepts a byte stream from the application side on wclk and writes each frame into the link layer's 2048x8 transmit buffer. On frame end it presents the frame length and a one-cycle tx_start. It then holds off the next frame for a length-scaled guard interval, because the buffer is single-ported per frame and has no done/ready feedback into the wclk domain.

## Interface
Parameters:
- MAX_LEN, 2047: maximum bytes per frame written to the buffer (header included); must be ≤ 2047.
- BYTE_CYCLES, 16: wclk cycles the downstream serializer needs per byte (4B5B on Rclk, expressed in wclk).
- GAP_CYCLES, 64: fixed guard added after each frame; must be ≥ 5 (downstream start stretcher depth).

Ports:
- wclk  in  1  write clock; all logic here is on wclk
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid & s_ready
- s_data  in  8  input byte
- s_last  in  1  marks last byte of frame
- dst_addr  in  8  header destination (used only with TX_LOADER_HDR_EN)
- src_addr  in  8  header source (used only with TX_LOADER_HDR_EN)
- tx_buf_wren  out  1  buffer write enable
- tx_buf_waddr  out  11  buffer write address
- tx_buf_wdata  out  8  buffer write data
- tx_data_len  out  11  frame length in bytes, stable from tx_start until next tx_start
- tx_start  out  1  one-cycle frame start pulse
- busy  out  1  high in every state except IDLE
- err_ovf  out  1  one-cycle pulse: oversize frame dropped

## Operation
- States: IDLE, HDR0, HDR1, LOAD, START, GAP, DROP.
- IDLE:
  - s_ready=0.
  - On s_valid: go to HDR0 if the header is enabled, else LOAD. ptr←0.
- HDR0/HDR1:
  - Write dst_addr at ptr 0, then src_addr at ptr 1. s_ready=0.
  - HDR1 → LOAD with ptr=2.
- LOAD: s_ready=1. On each handshake:
  - if ptr < MAX_LEN: write s_data at ptr, ptr←ptr+1. If s_last: len←ptr+1, go to START.
  - if ptr == MAX_LEN: no write. Go to DROP, or go straight to IDLE with err_ovf if s_last.
- DROP:
  - s_ready=1; bytes are discarded.
  - On s_last handshake: err_ovf pulse, go to IDLE.
  - No tx_start; tx_data_len unchanged.
- START:
  - Register tx_data_len←len and pulse tx_start.
  - Load guard counter with len*BYTE_CYCLES + GAP_CYCLES (unsigned, 20-bit; 2047*63+max GAP fits).
  - Go to GAP.
- GAP: decrement; at 0 go to IDLE. s_ready=0, so upstream back-pressure holds the next frame.
- s_valid may drop mid-frame; addresses stay contiguous.
- A zero-length frame is impossible, since s_last always rides on a byte.

## Timing
- Reset values: s_ready, tx_buf_wren, tx_start, busy, err_ovf = 0; tx_buf_waddr, tx_buf_wdata, tx_data_len = 0. State goes to IDLE, ptr and counter to 0.
- Reset mid-frame discards the partial frame. The next frame loads from address 0.
- Buffer write outputs are registered: a byte handshaked in cycle T appears on tx_buf_wren/waddr/wdata in T+1.
- Last byte handshaked at T: its write is at T+1, and tx_start with the new tx_data_len is at T+2.
- busy falls len*BYTE_CYCLES+GAP_CYCLES+1 cycles after tx_start.
- The earliest next-frame handshake comes 2 cycles after busy falls (IDLE→LOAD), or 4 cycles with the header.
- err_ovf pulses the cycle after the s_last handshake of a dropped frame.

## Configuration
- TX_LOADER_HDR_EN defined:
  - HDR0/HDR1 are compiled in and dst_addr/src_addr are written at addresses 0 and 1.
  - Payload starts at 2; max payload is MAX_LEN-2; tx_data_len includes the 2 header bytes.
- Undefined:
  - HDR states are absent and dst_addr/src_addr are ignored.
  - Payload starts at address 0 and tx_data_len equals the payload count.

## Structure
- Shared package tx_loader_pkg: state enumeration, ADDR_W=11, DATA_W=8, CNT_W=20, HDR_LEN=2.
- One sub-module, tx_gap_timer: load/decrement/zero-flag guard counter. The FSM and write path stay in tx_frame_loader.

## Test plan
- 4-byte frame 11,22,33,44, with BYTE_CYCLES=4 and GAP_CYCLES=8, header off:
  - writes go to addr 0–3; tx_data_len=4.
  - tx_start arrives 2 cycles after the last handshake; busy falls 25 cycles after tx_start.
- Two frames presented back-to-back: s_ready stays 0 throughout GAP. The second frame writes from addr 0 and gets a second tx_start with its own length.
- 2048-byte frame, MAX_LEN=2047:
  - addr 0–2046 are written; no tx_start; tx_data_len keeps its prior value.
  - err_ovf pulses once after s_last.
- TX_LOADER_HDR_EN with dst=A5, src=5A and payload 01,02,03: addr0=A5, addr1=5A, addr2–4=01,02,03; tx_data_len=5.
- rst asserted after 10 bytes of a frame: all outputs are 0 the next cycle and there is no tx_start. A following 2-byte frame writes addr 0–1 with len=2.
- s_valid toggled every other cycle across a 6-byte frame: 6 contiguous writes at addr 0–5; tx_data_len=6.
